truth_table_sweeper_3in: RTL and testbench

//  Upstream stimulus/score stage for 3-input logic circuits such as m0xE1.
//  On start, drives all 8 input combinations onto the DUT (in1,in2,in3) and

---
 rtl/truth_table_sweeper_3in_if.sv | 26 ++
 rtl/truth_table_sweeper_3in.sv | 135 +++++++++++++
 tb/tb_truth_table_sweeper_3in.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_3in_if.sv
// Control, result and DUT-facing signals of the 3-input truth-table sweeper.
// The master modport is the test environment; the slave modport is the sweeper.
interface truth_table_sweeper_3in_if;
    logic       start;
    logic       abort;
    logic       in1;
    logic       in2;
    logic       in3;
    logic       dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] observed;
    logic [7:0] mismatch;
    logic [7:0] unstable;

    modport master (
        output start, abort, dut_out,
        input  in1, in2, in3, busy, done, pass, observed, mismatch, unstable
    );

    modport slave (
        input  start, abort, dut_out,
        output in1, in2, in3, busy, done, pass, observed, mismatch, unstable
    );
endinterface

// File: rtl/truth_table_sweeper_3in.sv
// Drives all 8 input combinations into a 3-input circuit, majority-samples its
// synchronised output and scores the observed truth table against EXPECTED.
//
//  state  | meaning
//  IDLE   | waiting for start; vector held at 000 after reset/abort
//  APPLY  | vector held for SETTLE cycles plus 2 synchroniser cycles
//  SAMPLE | NSAMP consecutive samples of the synchronised output
//  DONE   | one-cycle completion; done pulses, pass is scored
module truth_table_sweeper_3in #(
    parameter logic [7:0] EXPECTED = 8'hE1,
    parameter int         SETTLE   = 4,
    parameter int         NSAMP    = 3,
    parameter int         CNT_W    = 8
) (
    input logic clk,
    input logic rst,
    truth_table_sweeper_3in_if.slave bus
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    // One extra counter bit so SETTLE+1 fits even when SETTLE = 2**CNT_W - 1.
    localparam logic [CNT_W:0] APPLY_LAST = (CNT_W + 1)'(SETTLE + 1);
    localparam logic [3:0]     SAMP_LAST  = 4'(NSAMP - 1);
    localparam logic [3:0]     HALF       = 4'(NSAMP / 2);
    localparam logic [3:0]     ALL_ONES   = 4'(NSAMP);

    state_t         state, state_nxt;
    logic [2:0]     idx;
    logic [CNT_W:0] cnt;
    logic [3:0]     samp_cnt;
    logic [3:0]     ones;
    logic [3:0]     ones_sum;
    logic [7:0]     observed;
    logic [7:0]     unstable;
    logic [7:0]     sampled;
    logic           pass_r;
    logic           sync1, sync2;
    logic           start_sweep;
    logic           abort_now;

    assign start_sweep = (state == IDLE) && bus.start && !bus.abort;
    assign abort_now   = (state != IDLE) && bus.abort;
    assign ones_sum    = ones + {3'b000, sync2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_sweep) state_nxt = APPLY;
            APPLY:   if (cnt == '0) state_nxt = SAMPLE;
            SAMPLE:  if (samp_cnt == '0) state_nxt = (idx == 3'd7) ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            samp_cnt <= '0;
            ones     <= '0;
            observed <= '0;
            unstable <= '0;
            sampled  <= '0;
            pass_r   <= 1'b0;
        end else begin
            sync1 <= bus.dut_out;
            sync2 <= sync1;
            // Partial observed/unstable survive an abort for post-mortem reads.
            if (abort_now) begin
                idx    <= '0;
                pass_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_sweep) begin
                            idx      <= '0;
                            cnt      <= APPLY_LAST;
                            observed <= '0;
                            unstable <= '0;
                            sampled  <= '0;
                            pass_r   <= 1'b0;
                        end
                    end
                    APPLY: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            samp_cnt <= SAMP_LAST;
                            ones     <= '0;
                        end
                    end
                    SAMPLE: begin
                        if (samp_cnt != '0) begin
                            samp_cnt <= samp_cnt - 1'b1;
                            ones     <= ones_sum;
                        end else begin
                            observed[3'd7 - idx] <= (ones_sum > HALF);
                            unstable[3'd7 - idx] <= (ones_sum != '0) && (ones_sum != ALL_ONES);
                            sampled[3'd7 - idx]  <= 1'b1;
                            if (idx != 3'd7) begin
                                idx <= idx + 1'b1;
                                cnt <= APPLY_LAST;
                            end
                        end
                    end
                    DONE: begin
                        pass_r <= (observed == EXPECTED);
                        idx    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in1      = idx[2];
    assign bus.in2      = idx[1];
    assign bus.in3      = idx[0];
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.pass     = (state == DONE) ? (observed == EXPECTED) : pass_r;
    assign bus.observed = observed;
    assign bus.unstable = unstable;
    // Rows not yet sampled in this sweep report no mismatch.
    assign bus.mismatch = (observed ^ EXPECTED) & sampled;
endmodule

// File: tb/tb_truth_table_sweeper_3in.sv
// Directed bench for truth_table_sweeper_3in driving an m0xE1 behavioural model,
// a tied-low output and a toggling output on one row.
module tb_truth_table_sweeper_3in;
    localparam logic [7:0] EXP = 8'hE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   dut_mode = 0;
    logic force_val = 1'b0;
    logic [7:0] ref_tab = 8'hE1;
    logic [2:0] vec;

    truth_table_sweeper_3in_if bus();
    truth_table_sweeper_3in dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // mode 0: m0xE1 circuit, mode 1: output stuck low, mode 2: driven by a task
    assign vec = {bus.in1, bus.in2, bus.in3};
    assign bus.dut_out = (dut_mode == 0) ? ref_tab[3'd7 - vec] :
                         (dut_mode == 1) ? 1'b0 : force_val;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_and_wait(output int lat);
        bus.start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) bus.start = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst = 1'b1;
        #12;
        vectors++;
        if ({bus.busy, bus.done, bus.pass, vec} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 000000", {bus.busy, bus.done, bus.pass, vec});
        end
        vectors++;
        if ({bus.observed, bus.mismatch, bus.unstable} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_tables got %h want 000000", {bus.observed, bus.mismatch, bus.unstable});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_sweep();
        int lat;
        dut_mode = 0;
        start_and_wait(lat);
        vectors++;
        if (lat !== 73) begin miscompares++; $display("FAIL good_latency got %0d want 73", lat); end
        vectors++;
        if (bus.observed !== 8'hE1) begin miscompares++; $display("FAIL good_observed got %h want e1", bus.observed); end
        vectors++;
        if ({bus.pass, bus.mismatch, bus.unstable} !== 17'h10000) begin
            miscompares++;
            $display("FAIL good_score got pass=%b mm=%h un=%h want 1/00/00", bus.pass, bus.mismatch, bus.unstable);
        end
        tick();
    endtask

    task automatic test_tied_low();
        int lat;
        dut_mode = 1;
        start_and_wait(lat);
        dut_mode = 0;
        vectors++;
        if (lat !== 73) begin miscompares++; $display("FAIL low_latency got %0d want 73", lat); end
        vectors++;
        if (bus.observed !== 8'h00) begin miscompares++; $display("FAIL low_observed got %h want 00", bus.observed); end
        vectors++;
        if (bus.mismatch !== 8'hE1) begin miscompares++; $display("FAIL low_mismatch got %h want e1", bus.mismatch); end
        vectors++;
        if ({bus.pass, bus.unstable} !== 9'h000) begin
            miscompares++;
            $display("FAIL low_pass_unstable got %b/%h want 0/00", bus.pass, bus.unstable);
        end
        tick();
    endtask

    // Row 3 output inverts every cycle starting at 1 when the vector lands; after
    // the 2-flop synchroniser the three samples are 1,0,1 -> majority 1.
    task automatic test_unstable();
        int lat, k;
        dut_mode = 0;
        bus.start = 1'b1;
        k = -1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (n == 1) bus.start = 1'b0;
            if (k < 0 && vec == 3'd3) begin
                k = 0;
                dut_mode = 2;
                force_val = 1'b1;
            end else if (k >= 0 && k < 9) begin
                k++;
                force_val = ~k[0];
                if (k == 9) dut_mode = 0;
            end
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        dut_mode = 0;
        vectors++;
        if (lat !== 73) begin miscompares++; $display("FAIL unst_latency got %0d want 73", lat); end
        vectors++;
        if (bus.unstable !== 8'h10) begin miscompares++; $display("FAIL unst_mask got %h want 10", bus.unstable); end
        vectors++;
        if (bus.observed !== 8'hF1) begin miscompares++; $display("FAIL unst_observed got %h want f1", bus.observed); end
        vectors++;
        if ({bus.pass, bus.mismatch} !== 9'h010) begin
            miscompares++;
            $display("FAIL unst_score got %b/%h want 0/10", bus.pass, bus.mismatch);
        end
        tick();
    endtask

    task automatic test_abort();
        int lat;
        logic saw_done;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_start_idle got busy=%b want 0", bus.busy); end
        tick();
        saw_done = 1'b0;
        bus.start = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            tick();
            if (n == 1) bus.start = 1'b0;
            if (bus.done) saw_done = 1'b1;
            if (n == 30) bus.abort = 1'b1;
            if (n == 31) begin
                bus.abort = 1'b0;
                vectors++;
                if ({bus.busy, vec} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL abort_idle got busy=%b vec=%b want 0/000", bus.busy, vec);
                end
                vectors++;
                if ({bus.observed, bus.mismatch, bus.unstable} !== 24'hE00000) begin
                    miscompares++;
                    $display("FAIL abort_partial got %h want e00000", {bus.observed, bus.mismatch, bus.unstable});
                end
            end
        end
        vectors++;
        if (saw_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got done seen=%b want 0", saw_done); end
        start_and_wait(lat);
        vectors++;
        if (lat !== 73 || bus.observed !== 8'hE1) begin
            miscompares++;
            $display("FAIL abort_restart got lat=%0d obs=%h want 73/e1", lat, bus.observed);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int done_n;
        done_n = -1;
        bus.start = 1'b1;
        for (int n = 1; n <= 76; n++) begin
            tick();
            if (n == 1) begin
                bus.start = 1'b0;
                vectors++;
                if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b want 1", bus.busy); end
            end
            if (n == 20) bus.start = 1'b1;
            if (n == 21) bus.start = 1'b0;
            if (bus.done && done_n < 0) done_n = n;
            if (n == 73) bus.start = 1'b1;
            if (n == 74) begin
                bus.start = 1'b0;
                vectors++;
                if ({bus.busy, bus.pass} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL b2b_after_done got busy=%b pass=%b want 0/1", bus.busy, bus.pass);
                end
            end
            if (n == 75) begin
                vectors++;
                if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_start_in_done got busy=%b want 0", bus.busy); end
            end
        end
        vectors++;
        if (done_n !== 73) begin miscompares++; $display("FAIL b2b_latency got %0d want 73", done_n); end
    endtask

    task automatic test_abort_in_done();
        logic done_at_73;
        done_at_73 = 1'b0;
        bus.start = 1'b1;
        for (int n = 1; n <= 74; n++) begin
            tick();
            if (n == 1) bus.start = 1'b0;
            if (n == 73) begin
                done_at_73 = bus.done;
                bus.abort = 1'b1;
            end
            if (n == 74) begin
                bus.abort = 1'b0;
                vectors++;
                if ({done_at_73, bus.busy, bus.pass} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL abort_done got done73=%b busy=%b pass=%b want 1/0/0", done_at_73, bus.busy, bus.pass);
                end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.start = 1'b1;
        for (int n = 1; n <= 48; n++) begin
            tick();
            if (n == 1) bus.start = 1'b0;
        end
        vectors++;
        if ({vec, bus.observed} !== {3'd5, 8'hE0}) begin
            miscompares++;
            $display("FAIL rstmid_pre got vec=%b obs=%h want 101/e0", vec, bus.observed);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.pass, vec, bus.observed, bus.mismatch, bus.unstable} !== 30'h0) begin
            miscompares++;
            $display("FAIL rstmid_async got busy=%b vec=%b obs=%h mm=%h un=%h want all 0",
                     bus.busy, vec, bus.observed, bus.mismatch, bus.unstable);
        end
        tick();
        rst = 1'b0;
        tick();
        start_and_wait(lat);
        vectors++;
        if (lat !== 73 || bus.observed !== 8'hE1 || bus.pass !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_sweep got lat=%0d obs=%h pass=%b want 73/e1/1", lat, bus.observed, bus.pass);
        end
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_good_sweep();
        test_tied_low();
        test_unstable();
        test_abort();
        test_back_to_back();
        test_abort_in_done();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
